// File: rtl/commit_trace_buffer.sv
// Commit trace buffer: records retired instructions around a PC trigger, then drains oldest-first.
// Optional macro COMMIT_TRACE_FILTER_EN records only commits that write a non-zero register.
module commit_trace_buffer #(
   parameter int DEPTH = 16,
   parameter int PC_W  = 12,
   parameter int POST  = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     commit_valid,
   input  logic [PC_W-1:0]          commit_pc,
   input  logic [31:0]              commit_insn,
   input  logic                     commit_we,
   input  logic [4:0]               commit_rd,
   input  logic [31:0]              commit_wdata,
   input  logic                     arm,
   input  logic                     clear,
   input  logic                     stop_mode,
   input  logic                     trig_en,
   input  logic [PC_W-1:0]          trig_pc,
   output logic                     rd_valid,
   input  logic                     rd_ready,
   output logic [PC_W-1:0]          rd_pc,
   output logic [31:0]              rd_insn,
   output logic                     rd_we,
   output logic [4:0]               rd_rd,
   output logic [31:0]              rd_wdata,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     triggered,
   output logic                     overflow,
   output logic                     busy
);
   // state    | meaning
   // IDLE     | buffer inactive, waiting for arm
   // CAPTURE  | recording commits, watching for the trigger PC
   // POSTTRIG | trigger seen, recording the remaining post-trigger commits
   // DONE     | capture finished, entries drained oldest-first
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL   = CW'(DEPTH);
   localparam logic [CW-1:0] POST_N = CW'(POST);

   typedef enum logic [1:0] {IDLE, CAPTURE, POSTTRIG, DONE} state_t;

   typedef struct packed {
      logic [PC_W-1:0] pc;
      logic [31:0]     insn;
      logic            we;
      logic [4:0]      rd;
      logic [31:0]     wdata;
   } entry_t;

   state_t          state;
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [CW-1:0]   post_left;
   logic            qualify;
   logic            capturing;
   logic            full;
   logic            hit;
   logic            wr_en;
   entry_t          mem [DEPTH];
   entry_t          head;

`ifdef COMMIT_TRACE_FILTER_EN
   assign qualify = commit_valid && commit_we && (commit_rd != 5'd0);
`else
   assign qualify = commit_valid;
`endif

   assign capturing = (state == CAPTURE) || (state == POSTTRIG);
   assign full      = (count == FULL);
   assign hit       = trig_en && (commit_pc == trig_pc);
   // in stop mode a full buffer never accepts a write, even if stop_mode was raised late
   assign wr_en     = !clear && capturing && qualify && !(stop_mode && full);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         wr_ptr    <= '0;
         count     <= '0;
         post_left <= '0;
         triggered <= 1'b0;
         overflow  <= 1'b0;
      end else if (clear) begin
         state     <= IDLE;
         count     <= '0;
         triggered <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (arm) begin
                  state     <= CAPTURE;
                  count     <= '0;
                  triggered <= 1'b0;
                  overflow  <= 1'b0;
               end
            end
            CAPTURE, POSTTRIG: begin
               if (stop_mode && full) begin
                  state <= DONE;
               end else if (wr_en) begin
                  wr_ptr <= wr_ptr + AW'(1);
                  if (!full) count <= count + CW'(1);
                  else overflow <= 1'b1;
                  if (state == CAPTURE && hit) triggered <= 1'b1;
                  if (state == POSTTRIG) post_left <= post_left - CW'(1);
                  if (stop_mode && count == FULL - CW'(1)) begin
                     state <= DONE;
                  end else if (state == CAPTURE && hit) begin
                     post_left <= POST_N;
                     state     <= (POST == 0) ? DONE : POSTTRIG;
                  end else if (state == POSTTRIG && post_left == CW'(1)) begin
                     state <= DONE;
                  end
               end
            end
            DONE: begin
               if (count != '0 && rd_ready) begin
                  count <= count - CW'(1);
                  if (count == CW'(1)) state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= '{commit_pc, commit_insn, commit_we, commit_rd, commit_wdata};
   end

   // oldest entry sits count slots behind the write pointer; count==DEPTH aliases to wr_ptr
   assign rd_ptr   = wr_ptr - count[AW-1:0];
   assign head     = mem[rd_ptr];
   assign rd_valid = (state == DONE) && (count != '0);
   assign rd_pc    = head.pc;
   assign rd_insn  = head.insn;
   assign rd_we    = head.we;
   assign rd_rd    = head.rd;
   assign rd_wdata = head.wdata;
   assign busy     = capturing;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Bench for commit_trace_buffer: queue-based reference model plus directed scenarios.
module tb_commit_trace_buffer;
   localparam int DEPTH = 16;
   localparam int PC_W  = 12;
   localparam int POST  = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              commit_valid, commit_we, arm, clear, stop_mode, trig_en, rd_ready;
   logic [PC_W-1:0]   commit_pc, trig_pc;
   logic [31:0]       commit_insn, commit_wdata;
   logic [4:0]        commit_rd;
   logic              rd_valid, rd_we, triggered, overflow, busy;
   logic [PC_W-1:0]   rd_pc;
   logic [31:0]       rd_insn, rd_wdata;
   logic [4:0]        rd_rd;
   logic [4:0]        count;

   int checks = 0;
   int errors = 0;

   commit_trace_buffer #(.DEPTH(DEPTH), .PC_W(PC_W), .POST(POST)) dut (
      .clk(clk), .rst_n(rst_n), .commit_valid(commit_valid), .commit_pc(commit_pc),
      .commit_insn(commit_insn), .commit_we(commit_we), .commit_rd(commit_rd),
      .commit_wdata(commit_wdata), .arm(arm), .clear(clear), .stop_mode(stop_mode),
      .trig_en(trig_en), .trig_pc(trig_pc), .rd_valid(rd_valid), .rd_ready(rd_ready),
      .rd_pc(rd_pc), .rd_insn(rd_insn), .rd_we(rd_we), .rd_rd(rd_rd), .rd_wdata(rd_wdata),
      .count(count), .triggered(triggered), .overflow(overflow), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // reference model: a queue of recorded commits and a phase number
   typedef struct packed {
      logic [PC_W-1:0] pc;
      logic [31:0]     insn;
      logic            we;
      logic [4:0]      rd;
      logic [31:0]     wdata;
   } ent_t;

   ent_t q[$];
   int   phase = 0;          // 0 idle, 1 capture, 2 post-trigger, 3 done
   int   post_todo = 0;
   bit   m_trig = 0, m_ovf = 0;
   ent_t m_e;
   bit   m_qual;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete(); phase = 0; m_trig = 0; m_ovf = 0;
      end else if (clear) begin
         q.delete(); phase = 0; m_trig = 0; m_ovf = 0;
      end else if (phase == 0) begin
         if (arm) begin q.delete(); phase = 1; m_trig = 0; m_ovf = 0; end
      end else if (phase == 3) begin
         if (q.size() != 0 && rd_ready) begin
            void'(q.pop_front());
            if (q.size() == 0) phase = 0;
         end
      end else begin
`ifdef COMMIT_TRACE_FILTER_EN
         m_qual = commit_valid && commit_we && commit_rd != 0;
`else
         m_qual = commit_valid;
`endif
         if (stop_mode && q.size() == DEPTH) phase = 3;
         else if (m_qual) begin
            m_e = '{commit_pc, commit_insn, commit_we, commit_rd, commit_wdata};
            q.push_back(m_e);
            if (q.size() > DEPTH) begin void'(q.pop_front()); m_ovf = 1; end
            if (phase == 1 && trig_en && commit_pc == trig_pc) m_trig = 1;
            if (stop_mode && q.size() == DEPTH) phase = 3;
            else if (phase == 1 && trig_en && commit_pc == trig_pc) begin
               post_todo = POST;
               phase = (POST == 0) ? 3 : 2;
            end else if (phase == 2) begin
               post_todo--;
               if (post_todo == 0) phase = 3;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         check("m_count", 64'(count), 64'(q.size()));
         check("m_busy", 64'(busy), 64'(phase == 1 || phase == 2));
         check("m_rd_valid", 64'(rd_valid), 64'(phase == 3 && q.size() != 0));
         check("m_triggered", 64'(triggered), 64'(m_trig));
         check("m_overflow", 64'(overflow), 64'(m_ovf));
         if (phase == 3 && q.size() != 0) begin
            check("m_rd_pc", 64'(rd_pc), 64'(q[0].pc));
            check("m_rd_insn", 64'(rd_insn), 64'(q[0].insn));
            check("m_rd_we", 64'(rd_we), 64'(q[0].we));
            check("m_rd_rd", 64'(rd_rd), 64'(q[0].rd));
            check("m_rd_wdata", 64'(rd_wdata), 64'(q[0].wdata));
         end
      end
   end

   task automatic step();
      @(posedge clk); #2;
   endtask

   task automatic do_arm();
      arm = 1'b1; step(); arm = 1'b0;
   endtask

   task automatic send(input int n, input int first);
      for (int i = 0; i < n; i++) begin
         commit_valid = 1'b1;
         commit_pc    = PC_W'(first + i);
         commit_insn  = 32'hA500_0000 ^ 32'(first + i);
         commit_we    = 1'b1;
         commit_rd    = 5'((first + i) % 31 + 1);
         commit_wdata = 32'((first + i) * 3 + 7);
         step();
      end
      commit_valid = 1'b0;
   endtask

   task automatic drain(input int n, input int first);
      rd_ready = 1'b1;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         check("drain_valid", 64'(rd_valid), 64'd1);
         check("drain_pc", 64'(rd_pc), 64'(first + i));
         step();
      end
      rd_ready = 1'b0;
      @(negedge clk);
      check("drained_valid", 64'(rd_valid), 64'd0);
      check("drained_count", 64'(count), 64'd0);
      step();
   endtask

   initial begin
      rst_n = 1'b0; commit_valid = 0; commit_pc = '0; commit_insn = '0; commit_we = 0;
      commit_rd = '0; commit_wdata = '0; arm = 0; clear = 0; stop_mode = 0; trig_en = 0;
      trig_pc = '0; rd_ready = 0;
      #12;
      check("reset_count", 64'(count), 64'd0);
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_rd_valid", 64'(rd_valid), 64'd0);
      check("reset_trig_ovf", 64'({triggered, overflow}), 64'd0);
      rst_n = 1'b1;
      step();

      // short capture around a trigger at PC 5
      trig_en = 1; trig_pc = 12'd5; stop_mode = 0;
      do_arm();
      send(10, 0);
      @(negedge clk);
      check("t1_count", 64'(count), 64'd10);
      check("t1_trig", 64'(triggered), 64'd1);
      check("t1_ovf", 64'(overflow), 64'd0);
      check("t1_busy", 64'(busy), 64'd0);
      step();
      drain(10, 0);

      // wrap-around with overflow, trigger late
      trig_pc = 12'd25;
      do_arm();
      send(30, 0);
      @(negedge clk);
      check("t2_count", 64'(count), 64'd16);
      check("t2_ovf", 64'(overflow), 64'd1);
      check("t2_trig", 64'(triggered), 64'd1);
      step();
      drain(16, 14);
      check("t2_trig_held", 64'(triggered), 64'd1);

      // stop-when-full, no trigger; then readout back-pressure
      stop_mode = 1; trig_en = 0;
      do_arm();
      send(20, 0);
      @(negedge clk);
      check("t3_count", 64'(count), 64'd16);
      check("t3_ovf", 64'(overflow), 64'd0);
      check("t3_trig", 64'(triggered), 64'd0);
      step();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("t4_hold_pc", 64'(rd_pc), 64'd0);
         check("t4_hold_count", 64'(count), 64'd16);
         step();
      end
      rd_ready = 1'b1; step(); rd_ready = 1'b0;
      @(negedge clk);
      check("t4_count_dec", 64'(count), 64'd15);
      check("t4_next_pc", 64'(rd_pc), 64'd1);
      step();
      drain(15, 1);

      // asynchronous reset mid-capture, then a fresh capture
      stop_mode = 0; trig_en = 1; trig_pc = 12'd2;
      do_arm();
      trig_en = 0;
      send(7, 40);
      @(negedge clk);
      check("t5_pre_count", 64'(count), 64'd7);
      check("t5_pre_busy", 64'(busy), 64'd1);
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      check("t5_rst_count", 64'(count), 64'd0);
      check("t5_rst_busy", 64'(busy), 64'd0);
      check("t5_rst_valid", 64'(rd_valid), 64'd0);
      #3; rst_n = 1'b1;
      step();
      trig_en = 1;
      do_arm();
      send(7, 0);
      @(negedge clk);
      check("t5_fresh_count", 64'(count), 64'd7);
      check("t5_fresh_trig", 64'(triggered), 64'd1);
      step();
      drain(7, 0);

      // clear aborts a capture and wins over a same-cycle arm
      do_arm();
      send(3, 100);
      clear = 1'b1; arm = 1'b1; step(); clear = 1'b0; arm = 1'b0;
      @(negedge clk);
      check("t6_clear_count", 64'(count), 64'd0);
      check("t6_clear_busy", 64'(busy), 64'd0);
      step();

`ifdef COMMIT_TRACE_FILTER_EN
      trig_en = 0;
      do_arm();
      for (int i = 0; i < 8; i++) begin
         commit_valid = 1; commit_pc = PC_W'(i); commit_insn = 32'(i);
         commit_we = (i % 2 == 0); commit_rd = 5'd3; commit_wdata = 32'(i);
         step();
      end
      commit_we = 1; commit_rd = 5'd0; step();
      commit_valid = 0;
      @(negedge clk);
      check("t7_filter_count", 64'(count), 64'd4);
      step();
      clear = 1'b1; step(); clear = 1'b0;
      step();
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
